// File: rtl/mem_acceso.sv
// MEM stage of the pipeline: data memory with configurable wait states and a MEM/WB register.
// Defining MEM_CONTADORES_EN adds load/store/stall event counters as outputs.
module mem_acceso #(
  parameter int unsigned PROFUNDIDAD = 64,
  parameter int unsigned LATENCIA    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valido_MEM,
  input  logic [31:0] resultado_alu_MEM,
  input  logic [31:0] dr2_MEM,
  input  logic [4:0]  registro_destino_MEM,
  input  logic        reg_escribir_MEM,
  input  logic        mem_a_reg_MEM,
  input  logic        mem_leer_MEM,
  input  logic        mem_escribir_MEM,
  output logic        detener,
  output logic        valido_WB,
  output logic [31:0] dato_leido_WB,
  output logic [31:0] resultado_alu_WB,
  output logic [4:0]  registro_destino_WB,
  output logic        reg_escribir_WB,
  output logic        mem_a_reg_WB,
  output logic        error_alineacion_WB
`ifdef MEM_CONTADORES_EN
  ,
  output logic [31:0] cuenta_cargas,
  output logic [31:0] cuenta_almacenamientos,
  output logic [31:0] cuenta_ciclos_detenidos
`endif
);

  localparam int unsigned AW        = $clog2(PROFUNDIDAD);
  localparam logic [2:0]  LatCnt    = 3'(LATENCIA);
  localparam bit          ConEspera = (LATENCIA != 0);

  typedef enum logic [0:0] {StReposo, StEspera} estado_e;

  estado_e     estado_q, estado_d;
  logic [2:0]  cuenta_q, cuenta_d;
  logic [31:0] mem [PROFUNDIDAD];

  logic          es_memop;
  logic          desalineado;
  logic          lectura;
  logic [AW-1:0] indice;
  logic          detener_int;
  logic          completar;
  logic          acceso_ok;
  logic          escribir_mem;
  logic          leer_mem;
  logic [31:0]   dato_d;

  assign es_memop    = valido_MEM & (mem_leer_MEM | mem_escribir_MEM);
  assign desalineado = |resultado_alu_MEM[1:0];
  // A simultaneous read and write is treated as a write only.
  assign lectura     = mem_leer_MEM & ~mem_escribir_MEM;
  assign indice      = resultado_alu_MEM[AW+1:2];

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q <= StReposo;
      cuenta_q <= 3'd0;
    end else begin
      estado_q <= estado_d;
      cuenta_q <= cuenta_d;
    end
  end

  // Next-state logic
  always_comb begin
    estado_d = estado_q;
    cuenta_d = cuenta_q;
    unique case (estado_q)
      StReposo: begin
        if (es_memop && !desalineado && ConEspera) begin
          estado_d = StEspera;
          cuenta_d = LatCnt;
        end
      end
      StEspera: begin
        if (!valido_MEM) begin
          estado_d = StReposo;
          cuenta_d = 3'd0;
        end else begin
          cuenta_d = cuenta_q - 3'd1;
          if (cuenta_q == 3'd1) begin
            estado_d = StReposo;
          end
        end
      end
      default: begin
        estado_d = StReposo;
        cuenta_d = 3'd0;
      end
    endcase
  end

  // Output logic; an entry dropped while waiting neither completes nor stalls.
  always_comb begin
    detener_int = 1'b0;
    completar   = 1'b0;
    unique case (estado_q)
      StReposo: begin
        if (es_memop && !desalineado && ConEspera) begin
          detener_int = 1'b1;
        end else begin
          completar = 1'b1;
        end
      end
      StEspera: begin
        if (valido_MEM) begin
          if (cuenta_q == 3'd1) begin
            completar = 1'b1;
          end else begin
            detener_int = 1'b1;
          end
        end
      end
      default: begin
        detener_int = 1'b0;
        completar   = 1'b0;
      end
    endcase
  end

  assign detener      = detener_int & ~reset;
  assign acceso_ok    = completar & es_memop & ~desalineado & ~reset;
  assign escribir_mem = acceso_ok & mem_escribir_MEM;
  assign leer_mem     = acceso_ok & lectura;
  assign dato_d       = leer_mem ? mem[indice] : 32'd0;

  // Data memory is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (escribir_mem) begin
      mem[indice] <= dr2_MEM;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valido_WB           <= 1'b0;
      dato_leido_WB       <= 32'd0;
      resultado_alu_WB    <= 32'd0;
      registro_destino_WB <= 5'd0;
      reg_escribir_WB     <= 1'b0;
      mem_a_reg_WB        <= 1'b0;
      error_alineacion_WB <= 1'b0;
    end else if (completar) begin
      valido_WB           <= valido_MEM;
      dato_leido_WB       <= dato_d;
      resultado_alu_WB    <= resultado_alu_MEM;
      registro_destino_WB <= registro_destino_MEM;
      reg_escribir_WB     <= reg_escribir_MEM;
      mem_a_reg_WB        <= mem_a_reg_MEM;
      error_alineacion_WB <= es_memop & desalineado;
    end else begin
      valido_WB           <= 1'b0;
      dato_leido_WB       <= 32'd0;
      resultado_alu_WB    <= 32'd0;
      registro_destino_WB <= 5'd0;
      reg_escribir_WB     <= 1'b0;
      mem_a_reg_WB        <= 1'b0;
      error_alineacion_WB <= 1'b0;
    end
  end

`ifdef MEM_CONTADORES_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cuenta_cargas           <= 32'd0;
      cuenta_almacenamientos  <= 32'd0;
      cuenta_ciclos_detenidos <= 32'd0;
    end else begin
      if (leer_mem) begin
        cuenta_cargas <= cuenta_cargas + 32'd1;
      end
      if (escribir_mem) begin
        cuenta_almacenamientos <= cuenta_almacenamientos + 32'd1;
      end
      if (detener) begin
        cuenta_ciclos_detenidos <= cuenta_ciclos_detenidos + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_acceso.sv
// Bench for mem_acceso: three instances (LATENCIA 2, 0, 3), vector table plus scoreboard
// of WB results, with hand sequences for reset-in-wait, abort and event counters.
module tb_mem_acceso;

  localparam int NDUT = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        valido_m [NDUT];
  logic [31:0] alu_m    [NDUT];
  logic [31:0] dr2_m    [NDUT];
  logic [4:0]  rdst_m   [NDUT];
  logic        rw_m     [NDUT];
  logic        m2r_m    [NDUT];
  logic        leer_m   [NDUT];
  logic        escr_m   [NDUT];

  logic        det      [NDUT];
  logic        vwb      [NDUT];
  logic [31:0] dato_wb  [NDUT];
  logic [31:0] alu_wb   [NDUT];
  logic [4:0]  rdst_wb  [NDUT];
  logic        rw_wb    [NDUT];
  logic        m2r_wb   [NDUT];
  logic        err_wb   [NDUT];
`ifdef MEM_CONTADORES_EN
  logic [31:0] c_cargas [NDUT];
  logic [31:0] c_alm    [NDUT];
  logic [31:0] c_det    [NDUT];
`endif

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    mem_acceso #(
      .PROFUNDIDAD(64),
      .LATENCIA   (g == 0 ? 2 : (g == 1 ? 0 : 3))
    ) u_dut (
      .clk                 (clk),
      .reset               (reset),
      .valido_MEM          (valido_m[g]),
      .resultado_alu_MEM   (alu_m[g]),
      .dr2_MEM             (dr2_m[g]),
      .registro_destino_MEM(rdst_m[g]),
      .reg_escribir_MEM    (rw_m[g]),
      .mem_a_reg_MEM       (m2r_m[g]),
      .mem_leer_MEM        (leer_m[g]),
      .mem_escribir_MEM    (escr_m[g]),
      .detener             (det[g]),
      .valido_WB           (vwb[g]),
      .dato_leido_WB       (dato_wb[g]),
      .resultado_alu_WB    (alu_wb[g]),
      .registro_destino_WB (rdst_wb[g]),
      .reg_escribir_WB     (rw_wb[g]),
      .mem_a_reg_WB        (m2r_wb[g]),
      .error_alineacion_WB (err_wb[g])
`ifdef MEM_CONTADORES_EN
      ,
      .cuenta_cargas          (c_cargas[g]),
      .cuenta_almacenamientos (c_alm[g]),
      .cuenta_ciclos_detenidos(c_det[g])
`endif
    );
    initial for (int i = 0; i < 64; i++) u_dut.mem[i] = 32'd0;
  end

  typedef struct {
    int unsigned k;
    bit          vld, rd, wr;
    logic [31:0] addr, data;
    logic [31:0] exp_dato;
    bit          exp_err;
    int          exp_stall;
  } vec_t;

  typedef struct {
    int unsigned k;
    logic [31:0] dato, alu;
    logic [4:0]  rdst;
    logic [2:0]  flags;
  } sb_t;

  sb_t  sb[$];
  vec_t tab[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endfunction

  function automatic void add(input int unsigned k, input bit vld, rd, wr,
                              input logic [31:0] addr, data, exp_dato,
                              input bit exp_err, input int exp_stall);
    vec_t v;
    v.k = k; v.vld = vld; v.rd = rd; v.wr = wr; v.addr = addr; v.data = data;
    v.exp_dato = exp_dato; v.exp_err = exp_err; v.exp_stall = exp_stall;
    tab.push_back(v);
  endfunction

  task automatic set_idle();
    for (int k = 0; k < NDUT; k++) begin
      valido_m[k] = 1'b0; alu_m[k] = '0; dr2_m[k] = '0; rdst_m[k] = '0;
      rw_m[k] = 1'b0; m2r_m[k] = 1'b0; leer_m[k] = 1'b0; escr_m[k] = 1'b0;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 just after the completion edge.
  task automatic issue(input int unsigned k, input bit vld, rd, wr,
                       input logic [31:0] addr, data, input logic [4:0] rdst,
                       input logic [31:0] exp_dato, input bit exp_err, input int exp_stall);
    int  stalls;
    sb_t e;
    stalls = 0;
    set_idle();
    valido_m[k] = vld; leer_m[k] = rd; escr_m[k] = wr; alu_m[k] = addr; dr2_m[k] = data;
    rdst_m[k] = rdst; rw_m[k] = rd; m2r_m[k] = rd;
    if (vld) begin
      e.k = k; e.dato = exp_dato; e.alu = addr; e.rdst = rdst; e.flags = {rd, rd, exp_err};
      sb.push_back(e);
    end
    @(negedge clk);
    while (det[k] && stalls < 20) begin
      stalls++;
      @(negedge clk);
      chk($sformatf("bubble k%0d a%08h", k, addr), 32'(vwb[k]), 32'd0);
    end
    chk($sformatf("stall k%0d a%08h", k, addr), stalls, exp_stall);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < NDUT; k++) begin
      if (!reset && vwb[k]) begin
        sb_t e;
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_wb k%0d: got valido_WB=1 expected none", k);
        end else begin
          e = sb.pop_front();
          chk("wb_dut", k, e.k);
          chk("dato_leido_WB", dato_wb[k], e.dato);
          chk("resultado_alu_WB", alu_wb[k], e.alu);
          chk("registro_destino_WB", 32'(rdst_wb[k]), 32'(e.rdst));
          chk("flags_WB", 32'({rw_wb[k], m2r_wb[k], err_wb[k]}), 32'(e.flags));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    set_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      chk($sformatf("rst_detener k%0d", k), 32'(det[k]), 32'd0);
      chk($sformatf("rst_valido k%0d", k), 32'(vwb[k]), 32'd0);
      chk($sformatf("rst_dato k%0d", k), dato_wb[k], 32'd0);
      chk($sformatf("rst_err k%0d", k), 32'(err_wb[k]), 32'd0);
`ifdef MEM_CONTADORES_EN
      chk($sformatf("rst_cnt k%0d", k), c_cargas[k] | c_alm[k] | c_det[k], 32'd0);
`endif
    end
    @(posedge clk); #1;
    reset = 1'b0;

    // k, vld, rd, wr, addr, data, exp_dato, exp_err, exp_stall
    add(0, 1, 0, 1, 32'h10,  32'hDEADBEEF, 32'h0,        0, 2);
    add(0, 1, 1, 0, 32'h10,  32'h0,        32'hDEADBEEF, 0, 2);
    add(0, 1, 1, 0, 32'h102, 32'h0,        32'h0,        1, 0);
    add(0, 1, 1, 0, 32'h100, 32'h0,        32'h0,        0, 2);
    add(0, 1, 0, 1, 32'h100, 32'h55,       32'h0,        0, 2);
    add(0, 1, 1, 0, 32'h0,   32'h0,        32'h55,       0, 2);
    add(0, 1, 0, 0, 32'h12345678, 32'h0,   32'h0,        0, 0);
    add(0, 0, 1, 0, 32'h10,  32'h0,        32'h0,        0, 0);
    add(0, 1, 1, 1, 32'h20,  32'hA5A5A5A5, 32'h0,        0, 2);
    add(0, 1, 1, 0, 32'h20,  32'h0,        32'hA5A5A5A5, 0, 2);
    add(0, 1, 0, 1, 32'h11,  32'hFFFF,     32'h0,        1, 0);
    add(0, 1, 1, 0, 32'h10,  32'h0,        32'hDEADBEEF, 0, 2);
    add(1, 1, 0, 1, 32'h0,   32'h11111111, 32'h0,        0, 0);
    add(1, 1, 0, 1, 32'h4,   32'h22222222, 32'h0,        0, 0);
    add(1, 1, 1, 0, 32'h4,   32'h0,        32'h22222222, 0, 0);
    add(1, 1, 1, 0, 32'h0,   32'h0,        32'h11111111, 0, 0);
    add(1, 1, 1, 0, 32'h3FC, 32'h0,        32'h0,        0, 0);

    for (int i = 0; i < tab.size(); i++) begin
      issue(tab[i].k, tab[i].vld, tab[i].rd, tab[i].wr, tab[i].addr, tab[i].data, 5'(i + 1),
            tab[i].exp_dato, tab[i].exp_err, tab[i].exp_stall);
    end
    set_idle();
    repeat (2) @(posedge clk); #1;

    // Event counters on the LATENCIA=3 instance: one load, one store.
    issue(2, 1, 1, 0, 32'h8, 32'h0,        5'd3, 32'h0, 0, 3);
    issue(2, 1, 0, 1, 32'h8, 32'hCAFEF00D, 5'd4, 32'h0, 0, 3);
    set_idle();
    repeat (2) @(posedge clk); #1;
`ifdef MEM_CONTADORES_EN
    chk("cuenta_cargas", c_cargas[2], 32'd1);
    chk("cuenta_almacenamientos", c_alm[2], 32'd1);
    chk("cuenta_ciclos_detenidos", c_det[2], 32'd6);
`endif

    // Drop valido_MEM while waiting: no write, no WB entry.
    valido_m[0] = 1'b1; escr_m[0] = 1'b1; alu_m[0] = 32'h20; dr2_m[0] = 32'h99;
    @(posedge clk); #1;
    valido_m[0] = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_valido", 32'(vwb[0]), 32'd0);
    @(posedge clk); #1;
    issue(0, 1, 1, 0, 32'h20, 32'h0, 5'd7, 32'hA5A5A5A5, 0, 2);
    set_idle();
    repeat (2) @(posedge clk); #1;

    // Reset while a store waits: stall drops at once, store never lands.
    valido_m[0] = 1'b1; escr_m[0] = 1'b1; alu_m[0] = 32'h10; dr2_m[0] = 32'h77777777;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("rst_wait_detener", 32'(det[0]), 32'd0);
    chk("rst_wait_valido", 32'(vwb[0]), 32'd0);
    set_idle();
    @(posedge clk); #1;
    reset = 1'b0;
    issue(0, 1, 1, 0, 32'h10, 32'h0, 5'd9, 32'hDEADBEEF, 0, 2);
    set_idle();
    repeat (3) @(posedge clk); #1;

    chk("sb_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
